univ_shift_reg: RTL

//  Parametrised universal shift register. Supports multiple lanes that share one control path.
//  Per-lane modes: hold, shift right, shift left, parallel load.
//  A shared shift counter flags each completed WIDTH-bit word, so the block can act as a

---
 rtl/shift_pkg.sv | 11 +
 rtl/shift_lane.sv | 42 ++++
 rtl/univ_shift_reg.sv | 85 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared mode encoding for the universal shift register and its lanes.
package shift_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SHR  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SHL  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_lane.sv
// One lane of the universal shift register: storage plus hold/shift/load selection.
module shift_lane
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic              ser_in_r,
    input  logic              ser_in_l,
    input  logic [WIDTH-1:0]  par_in,
    output logic [WIDTH-1:0]  q,
    output logic              end_r,
    output logic              end_l
);

    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_SHR:  q_nxt = {ser_in_r, q[WIDTH-1:1]};
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], ser_in_l};
            MODE_LOAD: q_nxt = par_in;
            default:   q_nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= q_nxt;
        end
    end

    assign end_r = q[0];
    assign end_l = q[WIDTH-1];

endmodule

// File: rtl/univ_shift_reg.sv
// Multi-lane universal shift register with a shared word counter and optional
// registered serial outputs.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LANES   = 1,
    parameter int OUT_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [MODE_W-1:0]          mode,
    input  logic [LANES-1:0]           ser_in_r,
    input  logic [LANES-1:0]           ser_in_l,
    input  logic [LANES*WIDTH-1:0]     par_in,
    output logic [LANES*WIDTH-1:0]     par_out,
    output logic [LANES-1:0]           ser_out_r,
    output logic [LANES-1:0]           ser_out_l,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       word_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [LANES-1:0] end_r;
    logic [LANES-1:0] end_l;
    logic             is_shift;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        shift_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .mode     (mode),
            .ser_in_r (ser_in_r[k]),
            .ser_in_l (ser_in_l[k]),
            .par_in   (par_in[k*WIDTH +: WIDTH]),
            .q        (par_out[k*WIDTH +: WIDTH]),
            .end_r    (end_r[k]),
            .end_l    (end_l[k])
        );
    end

    assign is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

    // Counter wraps on the word-completing shift so it never reads WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (en) begin
                if (mode == MODE_LOAD) begin
                    shift_cnt <= '0;
                end else if (is_shift) begin
                    if (shift_cnt == CNT_W'(WIDTH - 1)) begin
                        shift_cnt <= '0;
                        word_done <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        // Free-running: these follow the register ends even while en is low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ser_out_r <= '0;
                ser_out_l <= '0;
            end else begin
                ser_out_r <= end_r;
                ser_out_l <= end_l;
            end
        end
    end else begin : g_out_comb
        assign ser_out_r = end_r;
        assign ser_out_l = end_l;
    end

endmodule
